// File: rtl/fetch_queue.sv
// Fetch front-end: owns the PC, reads the instruction ROM and queues {pc, word} pairs for decode.
// Optional combinational empty-queue bypass is enabled with `define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned     XLen        = 32,
    parameter logic [XLen-1:0] ResetVector = '0,
    parameter int unsigned     Depth       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    output logic [XLen-1:0]            rom_raddr_o,
    input  logic [31:0]                rom_rdata_i,
    input  logic                       redirect_i,
    input  logic [XLen-1:0]            redirect_pc_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [31:0]                instr_o,
    output logic [XLen-1:0]            instr_pc_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef struct packed {
        logic [XLen-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t          mem_q [Depth];
    logic [XLen-1:0] pc_q, pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic fifo_valid;
    logic full;
    logic bypass;
    logic bypass_take;
    logic pop;
    logic push;

    // Low PC bits are forced to zero on redirect, so these inputs never reach state.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        fifo_valid = (count_q != '0);
        full       = (count_q == CntW'(Depth));
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = ~fifo_valid & ~redirect_i;
`else
        bypass = 1'b0;
`endif
        bypass_take = bypass & instr_ready_i;
        pop         = fifo_valid & instr_ready_i & ~redirect_i;
        push        = ~redirect_i & (~full | pop) & ~bypass_take;

        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);

        if (redirect_i) begin
            pc_d     = {redirect_pc_i[XLen-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push || bypass_take) begin
                pc_d = pc_q + XLen'(4);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_comb begin
        instr_valid_o = fifo_valid | bypass;
        instr_o       = '0;
        instr_pc_o    = '0;
        if (fifo_valid) begin
            instr_o    = mem_q[rd_ptr_q].instr;
            instr_pc_o = mem_q[rd_ptr_q].pc;
        end else if (bypass) begin
            instr_o    = rom_rdata_i;
            instr_pc_o = pc_q;
        end
    end

    assign rom_raddr_o = pc_q;
    assign count_o     = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= ResetVector;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are gated by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: pc_q, instr: rom_rdata_i};
        end
    end

    pc_aligned_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rom_raddr_o[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, then a randomized scoreboard run.
module tb_fetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] rom_raddr_o;
    logic [31:0] rom_rdata_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // ROM[i] = A000_0000 + i, word indexed.
    assign rom_rdata_i = 32'hA000_0000 + (rom_raddr_o >> 2);

    fetch_queue #(
        .XLen        (32),
        .ResetVector (32'h0000_0000),
        .Depth       (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rom_raddr_o   (rom_raddr_o),
        .rom_rdata_i   (rom_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .count_o       (count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rstn;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  count;
        logic [31:0] raddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rstn, input logic rdy, input logic redir, input logic [31:0] rpc,
                       input logic valid, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [2:0] count, input logic [31:0] raddr);
        vecs.push_back('{rstn, rdy, redir, rpc, valid, pc, instr, count, raddr});
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mpc;
    exp_t        head;

    initial begin
        // Observations are taken before the edge that consumes each row's inputs.
        add(0, 1, 0, 0,      0, 0,     0,            0, 0);
        add(1, 1, 0, 0,      0, 0,     0,            0, 0);
        add(1, 1, 0, 0,      1, 0,     32'hA0000000, 1, 4);
        add(1, 1, 0, 0,      1, 4,     32'hA0000001, 1, 8);
        add(1, 1, 0, 0,      1, 8,     32'hA0000002, 1, 12);
        add(1, 1, 0, 0,      1, 12,    32'hA0000003, 1, 16);
        add(0, 0, 0, 0,      0, 0,     0,            0, 0);
        add(1, 0, 0, 0,      0, 0,     0,            0, 0);
        add(1, 0, 0, 0,      1, 0,     32'hA0000000, 1, 4);
        add(1, 0, 0, 0,      1, 0,     32'hA0000000, 2, 8);
        add(1, 0, 0, 0,      1, 0,     32'hA0000000, 3, 12);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 1, 0, 32'hA0000000, 4, 16);
        add(1, 1, 0, 0,      1, 0,     32'hA0000000, 4, 16);
        add(1, 0, 0, 0,      1, 4,     32'hA0000001, 4, 20);
        add(1, 1, 0, 0,      1, 4,     32'hA0000001, 4, 20);
        add(1, 1, 0, 0,      1, 8,     32'hA0000002, 4, 24);
        add(1, 1, 0, 0,      1, 12,    32'hA0000003, 4, 28);
        add(1, 1, 0, 0,      1, 16,    32'hA0000004, 4, 32);
        add(1, 0, 1, 32'h200, 1, 20,   32'hA0000005, 4, 36);
        add(1, 0, 0, 0,      0, 0,     0,            0, 32'h200);
        add(1, 0, 0, 0,      1, 32'h200, 32'hA0000080, 1, 32'h204);
        add(1, 0, 0, 0,      1, 32'h200, 32'hA0000080, 2, 32'h208);
        add(1, 0, 1, 32'h103, 1, 32'h200, 32'hA0000080, 3, 32'h20C);
        add(1, 0, 0, 0,      0, 0,     0,            0, 32'h100);
        add(1, 0, 0, 0,      1, 32'h100, 32'hA0000040, 1, 32'h104);
        add(1, 0, 0, 0,      1, 32'h100, 32'hA0000040, 2, 32'h108);
        add(0, 0, 0, 0,      0, 0,     0,            0, 0);
        add(1, 1, 0, 0,      0, 0,     0,            0, 0);
        add(1, 1, 0, 0,      1, 0,     32'hA0000000, 1, 4);
        add(1, 1, 1, 32'h40, 1, 4,     32'hA0000001, 1, 8);
        add(1, 1, 1, 32'h80, 0, 0,     0,            0, 32'h40);
        add(1, 1, 0, 0,      0, 0,     0,            0, 32'h80);
        add(1, 1, 0, 0,      1, 32'h80, 32'hA0000020, 1, 32'h84);
        add(1, 1, 1, 32'hFFFFFFFC, 1, 32'h84, 32'hA0000021, 1, 32'h88);
        add(1, 1, 0, 0,      0, 0,     0,            0, 32'hFFFFFFFC);
        add(1, 1, 0, 0,      1, 32'hFFFFFFFC, 32'hDFFFFFFF, 1, 0);
        add(1, 1, 0, 0,      1, 0,     32'hA0000000, 1, 4);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            rst_ni        = vecs[i].rstn;
            instr_ready_i = vecs[i].rdy;
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc;
            #1;
            check($sformatf("v%0d valid", i), 32'(instr_valid_o), 32'(vecs[i].valid));
            check($sformatf("v%0d pc", i), instr_pc_o, vecs[i].pc);
            check($sformatf("v%0d instr", i), instr_o, vecs[i].instr);
            check($sformatf("v%0d count", i), 32'(count_o), 32'(vecs[i].count));
            check($sformatf("v%0d raddr", i), rom_raddr_o, vecs[i].raddr);
        end

        // Scoreboard run: start from a known state with a redirect.
        @(negedge clk_i);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h400;
        instr_ready_i = 1'b0;
        sb.delete();
        mpc = 32'h400;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            instr_ready_i = ($urandom_range(0, 3) != 0) && !((c / 40) % 3 == 1);
            redirect_i    = ($urandom_range(0, 31) == 0);
            redirect_pc_i = $urandom;
            #1;
            check("sb count", 32'(count_o), sb.size());
            check("sb raddr", rom_raddr_o, mpc);
            check("sb valid", 32'(instr_valid_o), 32'(sb.size() != 0));
            if (redirect_i) begin
                sb.delete();
                mpc = {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (instr_valid_o && instr_ready_i) begin
                    if (sb.size() == 0) begin
                        check("sb pop on empty", 32'(instr_valid_o), 32'd0);
                    end else begin
                        head = sb.pop_front();
                        check("sb head pc", instr_pc_o, head.pc);
                        check("sb head instr", instr_o, head.instr);
                    end
                end
                if (sb.size() < 4) begin
                    sb.push_back('{mpc, 32'hA000_0000 + (mpc >> 2)});
                    mpc = mpc + 32'd4;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
